// File: rtl/reg_write_ctrl.sv
// ============================================================================
//  reg_write_ctrl
//  Three-way round-robin write arbiter in front of a register file, with a
//  sequencer that zeroes every register on request.
//  Rev 1.0
// ============================================================================
`default_nettype none

module reg_write_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [2:0]        REQ,
    input  logic [ADDR_W-1:0] REQ_ADDR0,
    input  logic [ADDR_W-1:0] REQ_ADDR1,
    input  logic [ADDR_W-1:0] REQ_ADDR2,
    input  logic [DATA_W-1:0] REQ_DATA0,
    input  logic [DATA_W-1:0] REQ_DATA1,
    input  logic [DATA_W-1:0] REQ_DATA2,
    output logic [2:0]        GNT,
    input  logic              CLEAR,
    output logic              CLEAR_BUSY,
    output logic              WRITE,
    output logic [ADDR_W-1:0] INADDRESS,
    output logic [DATA_W-1:0] IN
);

    localparam logic [0:0]        c_NORMAL    = 1'b0;
    localparam logic [0:0]        c_CLR       = 1'b1;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = '1;

    logic [0:0]        r_state;
    logic [ADDR_W-1:0] r_cnt;
    logic [1:0]        r_last;

    logic [2:0]        w_elig;
    logic              w_found;
    logic [1:0]        w_win;
    logic [1:0]        w_idx;
    logic [2:0]        w_onehot;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_enter_clr;
    logic              w_clr_done;
    logic              w_arb_en;

    function automatic logic [1:0] f_next(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // A requester holding GNT this cycle has already been served; masking it
    // gives a single requester one write every other cycle.
    assign w_elig = REQ & ~GNT;

    always_comb begin
        w_found = 1'b0;
        w_win   = 2'd0;
        w_idx   = f_next(r_last);
        for (int k = 0; k < 3; k++) begin
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
            w_idx = f_next(w_idx);
        end
    end

    always_comb begin
        w_onehot = 3'b001;
        w_addr   = REQ_ADDR0;
        w_data   = REQ_DATA0;
        case (w_win)
            2'd1: begin
                w_onehot = 3'b010;
                w_addr   = REQ_ADDR1;
                w_data   = REQ_DATA1;
            end
            2'd2: begin
                w_onehot = 3'b100;
                w_addr   = REQ_ADDR2;
                w_data   = REQ_DATA2;
            end
            default: ;
        endcase
    end

    // CLEAR is only seen in NORMAL, so a clear in progress cannot be restarted.
    assign w_enter_clr = (r_state == c_NORMAL) && CLEAR;
    assign w_clr_done  = (r_state == c_CLR) && (r_cnt == c_LAST_ADDR);
    assign w_arb_en    = ((r_state == c_NORMAL) && !CLEAR) || w_clr_done;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state    <= c_NORMAL;
            r_cnt      <= '0;
            r_last     <= 2'd2;
            GNT        <= 3'b000;
            WRITE      <= 1'b0;
            INADDRESS  <= '0;
            IN         <= '0;
            CLEAR_BUSY <= 1'b0;
        end else begin
            if (w_enter_clr) begin
                r_state    <= c_CLR;
                r_cnt      <= '0;
                GNT        <= 3'b000;
                WRITE      <= 1'b1;
                INADDRESS  <= '0;
                IN         <= '0;
                CLEAR_BUSY <= 1'b1;
            end else if (w_clr_done) begin
                r_state    <= c_NORMAL;
                r_cnt      <= '0;
                CLEAR_BUSY <= 1'b0;
            end else if (r_state == c_CLR) begin
                r_cnt     <= r_cnt + 1'b1;
                INADDRESS <= r_cnt + 1'b1;
            end

            // Arbitration on the exit edge lets a pending write follow the
            // last clear write with no bubble.
            if (w_arb_en) begin
                GNT   <= w_found ? w_onehot : 3'b000;
                WRITE <= w_found;
                if (w_found) begin
                    INADDRESS <= w_addr;
                    IN        <= w_data;
                    r_last    <= w_win;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_write_ctrl.sv
// ============================================================================
//  tb_reg_write_ctrl
//  Directed self-checking bench for reg_write_ctrl with a register-file model.
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_write_ctrl;

    logic       CLK;
    logic       RESET;
    logic [2:0] REQ;
    logic [2:0] REQ_ADDR0, REQ_ADDR1, REQ_ADDR2;
    logic [7:0] REQ_DATA0, REQ_DATA1, REQ_DATA2;
    logic [2:0] GNT;
    logic       CLEAR;
    logic       CLEAR_BUSY;
    logic       WRITE;
    logic [2:0] INADDRESS;
    logic [7:0] IN;

    int checks = 0;
    int errors = 0;
    logic [7:0] mem [0:7];

    reg_write_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .REQ        (REQ),
        .REQ_ADDR0  (REQ_ADDR0),
        .REQ_ADDR1  (REQ_ADDR1),
        .REQ_ADDR2  (REQ_ADDR2),
        .REQ_DATA0  (REQ_DATA0),
        .REQ_DATA1  (REQ_DATA1),
        .REQ_DATA2  (REQ_DATA2),
        .GNT        (GNT),
        .CLEAR      (CLEAR),
        .CLEAR_BUSY (CLEAR_BUSY),
        .WRITE      (WRITE),
        .INADDRESS  (INADDRESS),
        .IN         (IN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    end

    always @(posedge CLK) begin
        if (RESET && WRITE) mem[INADDRESS] <= IN;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [2:0] gnt, input logic wr,
                           input logic [2:0] addr, input logic [7:0] data, input logic busy);
        chk({tag, ".gnt"},  {29'd0, GNT},       {29'd0, gnt});
        chk({tag, ".wr"},   {31'd0, WRITE},     {31'd0, wr});
        chk({tag, ".addr"}, {29'd0, INADDRESS}, {29'd0, addr});
        chk({tag, ".data"}, {24'd0, IN},        {24'd0, data});
        chk({tag, ".busy"}, {31'd0, CLEAR_BUSY}, {31'd0, busy});
    endtask

    task automatic do_write(input int idx, input logic [2:0] addr, input logic [7:0] data);
        case (idx)
            0: begin REQ_ADDR0 = addr; REQ_DATA0 = data; REQ = 3'b001; end
            1: begin REQ_ADDR1 = addr; REQ_DATA1 = data; REQ = 3'b010; end
            default: begin REQ_ADDR2 = addr; REQ_DATA2 = data; REQ = 3'b100; end
        endcase
        tick();
        chk("wr_gnt", {29'd0, GNT}, {29'd0, REQ});
        chk("wr_en",  {31'd0, WRITE}, 32'd1);
        REQ = 3'b000;
        tick();
        chk("wr_idle", {31'd0, WRITE}, 32'd0);
    endtask

    initial begin
        RESET = 1'b0;
        CLEAR = 1'b0;
        REQ = 3'b000;
        REQ_ADDR0 = 3'd1; REQ_DATA0 = 8'h10;
        REQ_ADDR1 = 3'd2; REQ_DATA1 = 8'h20;
        REQ_ADDR2 = 3'd3; REQ_DATA2 = 8'h30;
        #2;
        chk_out("reset", 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);

        tick();
        RESET = 1'b1;

        // First edge after reset with all requesting goes to requester 0,
        // then strict rotation with no idle cycles.
        REQ = 3'b111;
        tick(); chk_out("rr0", 3'b001, 1'b1, 3'd1, 8'h10, 1'b0);
        tick(); chk_out("rr1", 3'b010, 1'b1, 3'd2, 8'h20, 1'b0);
        tick(); chk_out("rr2", 3'b100, 1'b1, 3'd3, 8'h30, 1'b0);
        tick(); chk_out("rr3", 3'b001, 1'b1, 3'd1, 8'h10, 1'b0);
        REQ = 3'b000;
        tick(); chk_out("idle_hold", 3'b000, 1'b0, 3'd1, 8'h10, 1'b0);

        // Single request.
        REQ = 3'b001; REQ_ADDR0 = 3'd1; REQ_DATA0 = 8'd42;
        tick(); chk_out("single", 3'b001, 1'b1, 3'd1, 8'd42, 1'b0);
        REQ = 3'b000;
        tick(); chk_out("single_end", 3'b000, 1'b0, 3'd1, 8'd42, 1'b0);
        chk("mem1", {24'd0, mem[1]}, 32'd42);

        // Back-to-back single requester: one write per two cycles.
        REQ = 3'b010; REQ_ADDR1 = 3'd3; REQ_DATA1 = 8'd14;
        tick(); chk_out("b2b_a", 3'b010, 1'b1, 3'd3, 8'd14, 1'b0);
        REQ_ADDR1 = 3'd5; REQ_DATA1 = 8'd46;
        tick(); chk_out("b2b_gap", 3'b000, 1'b0, 3'd3, 8'd14, 1'b0);
        tick(); chk_out("b2b_b", 3'b010, 1'b1, 3'd5, 8'd46, 1'b0);
        REQ = 3'b000;
        tick(); chk_out("b2b_end", 3'b000, 1'b0, 3'd5, 8'd46, 1'b0);

        do_write(2, 3'd7, 8'd62);
        chk("mem3", {24'd0, mem[3]}, 32'd14);
        chk("mem7", {24'd0, mem[7]}, 32'd62);

        // Clear wins over a simultaneous request; a second CLEAR mid-way is ignored.
        CLEAR = 1'b1;
        REQ = 3'b001; REQ_ADDR0 = 3'd2; REQ_DATA0 = 8'd99;
        tick(); chk_out("clr0", 3'b000, 1'b1, 3'd0, 8'h00, 1'b1);
        CLEAR = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk_out($sformatf("clr%0d", i), 3'b000, 1'b1, i[2:0], 8'h00, 1'b1);
            CLEAR = (i == 3);
        end
        CLEAR = 1'b0;
        tick(); chk_out("clr_exit", 3'b001, 1'b1, 3'd2, 8'd99, 1'b0);
        REQ = 3'b000;
        tick(); chk_out("clr_after", 3'b000, 1'b0, 3'd2, 8'd99, 1'b0);
        tick(); chk("no_restart", {31'd0, CLEAR_BUSY}, 32'd0);
        for (int i = 0; i < 8; i++)
            chk($sformatf("clr_mem%0d", i), {24'd0, mem[i]}, (i == 2) ? 32'd99 : 32'd0);

        // Reset mid-clear.
        do_write(0, 3'd5, 8'd55);
        do_write(0, 3'd6, 8'd66);
        do_write(0, 3'd7, 8'd77);
        CLEAR = 1'b1;
        tick();
        CLEAR = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk_out("pre_rst", 3'b000, 1'b1, 3'd4, 8'h00, 1'b1);
        #2;
        RESET = 1'b0;
        #1;
        chk_out("async_rst", 3'b000, 1'b0, 3'd0, 8'h00, 1'b0);
        tick();
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("post_rst_wr%0d", i), {31'd0, WRITE | CLEAR_BUSY}, 32'd0);
        end
        chk("keep5", {24'd0, mem[5]}, 32'd55);
        chk("keep6", {24'd0, mem[6]}, 32'd66);
        chk("keep7", {24'd0, mem[7]}, 32'd77);

        // Round-robin pointer restarts at requester 0.
        REQ = 3'b111;
        tick(); chk("rst_rr", {29'd0, GNT}, 32'd1);
        REQ = 3'b000;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reg_write_ctrl.md
REG_WRITE_CTRL -- requirements
Module: reg_write_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of the register-file write data.
REQ-002 Parameter ADDR_W, default 3, width of the register-file address; 2**ADDR_W registers to clear.
REQ-003 CLK  in  1  clock; all state updates on the rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 REQ  in  3  per-requester write request, bit i is requester i.
REQ-006 REQ_ADDR0, REQ_ADDR1, REQ_ADDR2  in  ADDR_W each  target register of requester 0/1/2.
REQ-007 REQ_DATA0, REQ_DATA1, REQ_DATA2  in  DATA_W each  write data of requester 0/1/2.
REQ-008 GNT  out  3  one-hot grant; GNT[i]=1 for exactly one cycle per accepted request.
REQ-009 CLEAR  in  1  request to zero every register, one register per cycle.
REQ-010 CLEAR_BUSY  out  1  high while the clear sequence drives the write port.
REQ-011 WRITE  out  1  register-file write enable.
REQ-012 INADDRESS  out  ADDR_W  register-file write address.
REQ-013 IN  out  DATA_W  register-file write data.

Function
REQ-014 All outputs SHALL be registered; no input SHALL reach an output combinationally.
REQ-015 States SHALL be NORMAL and CLR; NORMAL -> CLR when CLEAR=1 at an edge; CLR -> NORMAL at the edge after the write to address 2**ADDR_W-1 is presented.
REQ-016 In NORMAL, eligible set at each edge SHALL be REQ & ~GNT (a requester being granted this cycle is not re-granted next cycle).
REQ-017 Winner SHALL be chosen round-robin: search starts at requester (LAST+1) mod 3, LAST = index of the most recent grant.
REQ-018 On a win at edge k, outputs from edge k SHALL be GNT=one-hot(winner), WRITE=1, INADDRESS=REQ_ADDRi, IN=REQ_DATAi, LAST=winner.
REQ-019 With no eligible requester in NORMAL, GNT=0 and WRITE=0; INADDRESS and IN SHALL hold their previous values.
REQ-020 A requester SHALL hold REQ, address and data stable until it observes GNT[i]=1; the request is consumed at the edge ending that cycle.
REQ-021 Throughput SHALL be one write per cycle across requesters; one write per two cycles for a single requester.
REQ-022 CLEAR and any REQ sampled at the same edge in NORMAL: CLEAR SHALL win; no grant issued; requests stay pending.
REQ-023 In CLR, a 3-bit counter CNT SHALL drive INADDRESS=CNT, IN=0, WRITE=1, CLEAR_BUSY=1, GNT=0, CNT incrementing 0..2**ADDR_W-1 on consecutive cycles.
REQ-024 CLEAR_BUSY SHALL be high for exactly 2**ADDR_W consecutive cycles per clear.
REQ-025 CLEAR asserted while in CLR SHALL be ignored (no restart, no queued second clear).
REQ-026 At the CLR -> NORMAL edge, arbitration SHALL run normally, so a grant may issue on the same edge CLEAR_BUSY falls.
REQ-027 A grant issued the cycle before CLEAR is sampled SHALL complete unaffected (its write is already on the port).
REQ-028 CNT SHALL return to 0 on leaving CLR.

Reset
REQ-029 RESET=0 SHALL immediately, independent of CLK, force GNT=0, WRITE=0, INADDRESS=0, IN=0, CLEAR_BUSY=0, state NORMAL, CNT=0, LAST=2.
REQ-030 Reset during CLR SHALL abort the sequence; no further clear writes after RESET is released unless CLEAR is asserted again.
REQ-031 First edge after RESET release with REQ=3'b111 SHALL grant requester 0.

Verification
REQ-032 Single request: REQ=001, ADDR0=1, DATA0=42 -> next cycle GNT=001, WRITE=1, INADDRESS=1, IN=42; following cycle WRITE=0; reg file readback of reg 1 = 42.
REQ-033 Fairness: REQ=111 held continuously -> GNT sequence 001, 010, 100, 001, ... with no idle cycles.
REQ-034 Back-to-back single requester: REQ=010 held, data 14 then 46 -> GNT[1] high every other cycle, WRITE=1 only in grant cycles.
REQ-035 Clear: regs preloaded with 14 at addr 3 and 62 at addr 7, CLEAR pulsed with REQ=001 pending -> 8 cycles WRITE=1, IN=0, INADDRESS 0..7, CLEAR_BUSY=1, GNT=0; grant to requester 0 on the edge CLEAR_BUSY falls; all regs read 0 except the new write.
REQ-036 Reset mid-clear: RESET=0 asynchronously when INADDRESS=4 -> outputs 0 immediately; after release no writes occur with REQ=0, CLEAR=0; regs 5..7 keep prior values.
REQ-037 Re-CLEAR during CLR: CLEAR pulsed again at CNT=3 -> CLEAR_BUSY still high exactly 8 cycles total.
